id_ex_stage_skid: RTL

Parametrised ID/EX-style pipeline stage with a valid/ready handshake, a two-entry skid buffer, and flush support. It carries a wide data bundle (instruction, PC+4, operands, immediates, destination register) and a separate control bundle (ALU op, mux selects, memory and write-back enables). The stage supports stall and flush so hazard logic can apply back-pressure or insert bubbles without losing or duplicating instructions. It sits between decode and execute and can be instantiated unchanged at IF/ID, EX/MEM and MEM/WB.

---
 rtl/id_ex_stage_skid.sv | 99 +++++++++
 1 files changed

// File: rtl/id_ex_stage_skid.sv
// Pipeline register stage with a valid/ready handshake and a two-entry skid buffer.
// Flush empties both entries; controls are zeroed whenever an entry is invalid.
module id_ex_stage_skid #(
    parameter int DATA_W = 192,
    parameter int CTRL_W = 24
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    logic              out_valid_n, skid_valid_n;
    logic [DATA_W-1:0] out_data_n, skid_data_n;
    logic [CTRL_W-1:0] out_ctrl_n, skid_ctrl_n;
    logic [1:0]        occupancy_n;
    logic              accept, drain, load_out;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready comes only from registered state, so out_ready never reaches it combinationally.
    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready && !Flush;
    assign drain    = out_valid && out_ready;
    assign load_out = !out_valid || drain;

    always_comb begin
        out_valid_n  = out_valid;
        out_data_n   = out_data;
        out_ctrl_n   = out_ctrl;
        skid_valid_n = skid_valid;
        skid_data_n  = skid_data;
        skid_ctrl_n  = skid_ctrl;
        if (Flush) begin
            // Data registers are held; only valids and controls are cleared.
            out_valid_n  = 1'b0;
            out_ctrl_n   = '0;
            skid_valid_n = 1'b0;
            skid_ctrl_n  = '0;
        end else if (load_out) begin
            if (skid_valid) begin
                out_valid_n = 1'b1;
                out_data_n  = skid_data;
                out_ctrl_n  = skid_ctrl;
                if (accept) begin
                    skid_data_n = in_data;
                    skid_ctrl_n = in_ctrl;
                end else begin
                    skid_valid_n = 1'b0;
                    skid_ctrl_n  = '0;
                end
            end else if (accept) begin
                out_valid_n = 1'b1;
                out_data_n  = in_data;
                out_ctrl_n  = in_ctrl;
            end else begin
                out_valid_n = 1'b0;
                out_ctrl_n  = '0;
            end
        end else if (accept) begin
            skid_valid_n = 1'b1;
            skid_data_n  = in_data;
            skid_ctrl_n  = in_ctrl;
        end
        occupancy_n = {1'b0, out_valid_n} + {1'b0, skid_valid_n};
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ctrl   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_ctrl  <= '0;
            occupancy  <= 2'd0;
        end else begin
            out_valid  <= out_valid_n;
            out_data   <= out_data_n;
            out_ctrl   <= out_ctrl_n;
            skid_valid <= skid_valid_n;
            skid_data  <= skid_data_n;
            skid_ctrl  <= skid_ctrl_n;
            occupancy  <= occupancy_n;
        end
    end

endmodule
